// File: rtl/opcodes.sv
// ALU opcode set and flag-bit layout shared by the
// alu_seq datapath, its bus interface and benches.
package opcodes;

  typedef enum logic [3:0] {
    FnMem,
    FnADD,
    FnADC,
    FnSUB,
    FnAND,
    FnOR,
    FnNOT,
    FnLSL,
    FnLSR,
    FnMUL
  } alu_functions_t;

  localparam int FLAGS_Z = 0;
  localparam int FLAGS_C = 1;
  localparam int FLAGS_V = 2;
  localparam int FLAGS_N = 3;

  function automatic logic [3:0] pack_flags(
    input logic n,
    input logic v,
    input logic c,
    input logic z
  );
    logic [3:0] f;
    f          = '0;
    f[FLAGS_N] = n;
    f[FLAGS_V] = v;
    f[FLAGS_C] = c;
    f[FLAGS_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between an ALU client
// (master) and the sequential ALU (slave).
interface alu_seq_if #(
  parameter int WIDTH = 16
) ();
  import opcodes::*;

  logic             Start;
  alu_functions_t   AluOp;
  logic [WIDTH-1:0] Op1;
  logic [WIDTH-1:0] Op2;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [3:0]       Flags;

  modport master (
    output Start, AluOp, Op1, Op2,
    input  Busy, Done, Result, Flags
  );

  modport slave (
    input  Start, AluOp, Op1, Op2,
    output Busy, Done, Result, Flags
  );
endinterface

// File: rtl/alu_seq_comb.sv
// Single-cycle ALU datapath: result plus raw
// carry/borrow and overflow, no flag register.
module alu_seq_comb
  import opcodes::*;
#(
  parameter int WIDTH = 16
) (
  input  alu_functions_t   op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] res_o,
  output logic             c_o,
  output logic             v_o
);

  localparam int M = WIDTH - 1;

  logic         cin_add;
  logic [WIDTH:0] sum;
  logic [WIDTH:0] dif;
  logic         v_add;
  logic         v_sub;

  assign cin_add = (op_i == FnADC) & cin_i;
  assign sum = {1'b0, a_i} + {1'b0, b_i}
             + {{WIDTH{1'b0}}, cin_add};
  // Top bit of the widened difference is the borrow.
  assign dif = {1'b0, a_i} - {1'b0, b_i};

  assign v_add = (a_i[M] == b_i[M])
               & (sum[M] != a_i[M]);
  assign v_sub = (a_i[M] != b_i[M])
               & (dif[M] != a_i[M]);

  always_comb begin
    res_o = a_i;
    c_o   = 1'b0;
    v_o   = 1'b0;
    unique case (1'b1)
      (op_i == FnADD),
      (op_i == FnADC): begin
        res_o = sum[M:0];
        c_o   = sum[WIDTH];
        v_o   = v_add;
      end
      (op_i == FnSUB): begin
        res_o = dif[M:0];
        c_o   = dif[WIDTH];
        v_o   = v_sub;
      end
      (op_i == FnAND): res_o = a_i & b_i;
      (op_i == FnOR):  res_o = a_i | b_i;
      (op_i == FnNOT): res_o = ~a_i;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops plus bit-serial
// shifts and a shift-add multiplier behind one FSM.
module alu_seq
  import opcodes::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic     Clock,
  input logic     Reset,
  alu_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    MUL
  } state_e;

  state_e           state_q, state_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  alu_functions_t   op_q, op_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [3:0]       flg_q, flg_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] c_res;
  logic             c_c;
  logic             c_v;

  alu_seq_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .op_i (bus.AluOp),
    .a_i  (bus.Op1),
    .b_i  (bus.Op2),
    .cin_i(flg_q[FLAGS_C]),
    .res_o(c_res),
    .c_o  (c_c),
    .v_o  (c_v)
  );

  logic             idle;
  logic [SHW-1:0]   n;
  logic             sh_op;
  logic             left;
  logic [WIDTH-1:0] src;
  logic [WIDTH-1:0] sh_nxt;
  logic             sh_c;

  assign idle  = (state_q == IDLE);
  assign n     = bus.Op2[SHW-1:0];
  assign sh_op = (bus.AluOp == FnLSL)
               | (bus.AluOp == FnLSR);
  assign left  = idle ? (bus.AluOp == FnLSL)
                      : (op_q == FnLSL);
  assign src   = idle ? bus.Op1 : a_q;

  // First step runs on the accepting edge.
  assign sh_nxt = left ? {src[WIDTH-2:0], 1'b0}
                       : {1'b0, src[WIDTH-1:1]};
  assign sh_c   = left ? src[WIDTH-1] : src[0];

  logic [WIDTH-1:0] m_hi;
  logic [WIDTH-1:0] m_lo;
  logic [WIDTH-1:0] m_b;
  logic [WIDTH:0]   m_sum;
  logic [WIDTH-1:0] mhi_nxt;
  logic [WIDTH-1:0] mlo_nxt;

  assign m_hi  = idle ? '0 : hi_q;
  assign m_lo  = idle ? bus.Op2 : a_q;
  assign m_b   = idle ? bus.Op1 : b_q;
  assign m_sum = {1'b0, m_hi}
               + (m_lo[0] ? {1'b0, m_b} : '0);
  assign mhi_nxt = m_sum[WIDTH:1];
  assign mlo_nxt = {m_sum[0], m_lo[WIDTH-1:1]};

  logic             fin;
  logic [WIDTH-1:0] fin_res;
  logic             fin_c;
  logic             fin_v;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    op_d    = op_q;
    res_d   = res_q;
    flg_d   = flg_q;
    done_d  = 1'b0;
    fin     = 1'b0;
    fin_res = c_res;
    fin_c   = c_c;
    fin_v   = c_v;
    unique case (state_q)
      IDLE: begin
        if (bus.Start) begin
          op_d = bus.AluOp;
          a_d  = bus.Op1;
          b_d  = bus.Op2;
          unique case (1'b1)
            (sh_op && n == SHW'(1)): begin
              fin     = 1'b1;
              fin_res = sh_nxt;
              fin_c   = sh_c;
              fin_v   = 1'b0;
            end
            (sh_op && n > SHW'(1)): begin
              a_d     = sh_nxt;
              cnt_d   = n - SHW'(2);
              state_d = SHIFT;
            end
            (bus.AluOp == FnMUL): begin
              a_d     = mlo_nxt;
              hi_d    = mhi_nxt;
              b_d     = bus.Op1;
              cnt_d   = SHW'(WIDTH - 2);
              state_d = MUL;
            end
            default: fin = 1'b1;
          endcase
        end
      end
      SHIFT: begin
        a_d   = sh_nxt;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          fin     = 1'b1;
          fin_res = sh_nxt;
          fin_c   = sh_c;
          fin_v   = 1'b0;
        end
      end
      MUL: begin
        a_d   = mlo_nxt;
        hi_d  = mhi_nxt;
        cnt_d = cnt_q - SHW'(1);
        if (cnt_q == '0) begin
          state_d = IDLE;
          fin     = 1'b1;
          fin_res = mlo_nxt;
          fin_c   = |mhi_nxt;
          fin_v   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      res_d  = fin_res;
      flg_d  = pack_flags(fin_res[WIDTH-1], fin_v,
                          fin_c, fin_res == '0);
      done_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      op_q    <= FnMem;
      res_q   <= '0;
      flg_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      op_q    <= op_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      done_q  <= done_d;
    end
  end

  assign bus.Busy   = ~idle;
  assign bus.Done   = done_q;
  assign bus.Result = res_q;
  assign bus.Flags  = flg_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized + directed bench for alu_seq against
// an arithmetic reference model (WIDTH=16).
module tb_alu_seq;
  import opcodes::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  logic [3:0] mflags;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(
    .WIDTH(16)
  ) dut (
    .Clock(clk),
    .Reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input int op,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic cin,
                       output logic [15:0] r,
                       output logic [3:0] f,
                       output int lat);
    int ua, ub, sa, sb, t, sv, n;
    longint p;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    n  = ub % 16;
    c = 1'b0; v = 1'b0; lat = 1; r = a;
    case (op)
      1, 2: begin
        t  = ua + ub + (op == 2 ? int'(cin) : 0);
        sv = sa + sb + (op == 2 ? int'(cin) : 0);
        r  = 16'(t);
        c  = t > 65535;
        v  = sv > 32767 || sv < -32768;
      end
      3: begin
        r  = 16'(ua - ub);
        c  = ua < ub;
        sv = sa - sb;
        v  = sv > 32767 || sv < -32768;
      end
      4: r = a & b;
      5: r = a | b;
      6: r = ~a;
      7: begin
        r   = 16'(ua << n);
        c   = n > 0 && ((ua >> (16 - n)) & 1) == 1;
        lat = n > 0 ? n : 1;
      end
      8: begin
        r   = 16'(ua >> n);
        c   = n > 0 && ((ua >> (n - 1)) & 1) == 1;
        lat = n > 0 ? n : 1;
      end
      9: begin
        p   = longint'(ua) * longint'(ub);
        r   = 16'(p);
        c   = (p >> 16) != 0;
        lat = 16;
      end
      default: r = a;
    endcase
    f = {r[15], v, c, r == 16'h0};
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    bus.Start = 1'b1;
    bus.AluOp = FnADD;
    bus.Op1   = 16'h0001;
    bus.Op2   = 16'h0001;
    @(negedge clk);
    bus.Start = 1'b0;
    @(negedge clk);
    check("rst_busy", 32'(bus.Busy), 0);
    check("rst_done", 32'(bus.Done), 0);
    check("rst_res", 32'(bus.Result), 0);
    check("rst_flags", 32'(bus.Flags), 0);
    rst    = 1'b0;
    mflags = '0;
  endtask

  task automatic run_op(input int op,
                        input logic [15:0] a,
                        input logic [15:0] b);
    logic [15:0] er;
    logic [3:0]  ef;
    int lat, k, busy_n;
    model(op, a, b, mflags[1], er, ef, lat);
    bus.Start = 1'b1;
    bus.AluOp = alu_functions_t'(op);
    bus.Op1   = a;
    bus.Op2   = b;
    @(negedge clk);
    bus.Start = 1'b0;
    k = 1;
    busy_n = 0;
    while (!bus.Done && k < 40) begin
      if (bus.Busy) busy_n++;
      @(negedge clk);
      k++;
    end
    check($sformatf("lat op%0d", op), k, lat);
    check($sformatf("busy op%0d", op), busy_n, lat - 1);
    check("busy_at_done", 32'(bus.Busy), 0);
    check($sformatf("res op%0d", op), 32'(bus.Result), 32'(er));
    check($sformatf("flags op%0d", op), 32'(bus.Flags), 32'(ef));
    mflags = ef;
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] edges [4];
    edges = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    if ($urandom_range(3) == 0)
      return edges[$urandom_range(3)];
    return 16'($urandom);
  endfunction

  initial begin
    int k;
    logic seen;
    checks    = 0;
    failures  = 0;
    bus.Start = 1'b0;
    bus.AluOp = FnMem;
    bus.Op1   = '0;
    bus.Op2   = '0;
    do_reset();

    run_op(1, 16'h7FFF, 16'h0001);
    check("add_res", 32'(bus.Result), 32'h8000);
    check("add_flags", 32'(bus.Flags), 32'hC);
    run_op(3, 16'h0003, 16'h0005);
    check("sub_flags", 32'(bus.Flags), 32'hA);
    run_op(2, 16'h0001, 16'h0001);
    check("adc_res", 32'(bus.Result), 32'h0003);

    bus.Start = 1'b1;
    bus.AluOp = FnLSL;
    bus.Op1   = 16'h0001;
    bus.Op2   = 16'h0005;
    @(negedge clk);
    bus.Start = 1'b0;
    k = 1;
    while (!bus.Done && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 2) begin
        bus.Start = 1'b1;
        bus.AluOp = FnADD;
        bus.Op1   = 16'h1111;
        bus.Op2   = 16'h1111;
      end
      if (k == 3) bus.Start = 1'b0;
    end
    bus.Start = 1'b0;
    check("lsl_lat", k, 5);
    check("lsl_res", 32'(bus.Result), 32'h0020);
    check("lsl_flags", 32'(bus.Flags), 32'h0);
    @(negedge clk);
    check("lsl_no_2nd_done", 32'(bus.Done), 0);
    check("lsl_hold", 32'(bus.Result), 32'h0020);
    mflags = '0;

    run_op(9, 16'h0100, 16'h0100);
    check("mul_flags", 32'(bus.Flags), 32'h3);
    run_op(9, 16'h0003, 16'h0005);
    check("mul_res", 32'(bus.Result), 32'h000F);

    bus.Start = 1'b1;
    bus.AluOp = FnMUL;
    bus.Op1   = 16'h1234;
    bus.Op2   = 16'h0042;
    @(negedge clk);
    bus.Start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(bus.Busy), 0);
    check("abort_res", 32'(bus.Result), 0);
    check("abort_flags", 32'(bus.Flags), 0);
    seen = bus.Done;
    repeat (20) begin
      @(negedge clk);
      seen = seen | bus.Done;
    end
    check("abort_no_done", 32'(seen), 0);
    mflags = '0;

    run_op(8, 16'hA5A5, 16'h0000);
    check("lsr0_res", 32'(bus.Result), 32'hA5A5);

    for (int i = 0; i < 300; i++) begin
      run_op(int'($urandom_range(9)), pick(), pick());
      if ($urandom_range(3) == 0)
        repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 16, datapath width in bits; SHALL be >= 4.
REQ-002 Parameter SHW, default $clog2(WIDTH), shift-amount field width.
REQ-003 Clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 Reset  in  1  reset, synchronous, active-high.
REQ-005 Start  in  1  request; sampled only when Busy=0.
REQ-006 AluOp  in  opcodes::alu_functions_t  operation select, sampled with Start.
REQ-007 Op1  in  WIDTH  first operand, sampled with Start.
REQ-008 Op2  in  WIDTH  second operand or shift amount (Op2[SHW-1:0]), sampled with Start.
REQ-009 Busy  out  1  high while a multi-cycle operation is in progress.
REQ-010 Done  out  1  one-cycle pulse; Result and Flags are updated in the same cycle.
REQ-011 Result  out  WIDTH  registered result, held until the next Done.
REQ-012 Flags  out  4  registered {N,V,C,Z} at bit indices 3,2,1,0.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and MUL; Busy=1 exactly in SHIFT and MUL.
REQ-014 Start in IDLE SHALL latch Op1, Op2 and AluOp; Start while Busy=1 SHALL be ignored, with no effect on the in-flight operation.
REQ-015 FnMem, FnADD, FnADC, FnSUB, FnAND, FnOR, FnNOT and the default case SHALL remain in IDLE; Done follows Start by exactly 1 cycle.
REQ-016 ADD: Result = Op1+Op2 computed at WIDTH+1 bits; C = carry-out.
REQ-017 ADC: Result = Op1+Op2+Flags.C, using the registered C flag at Start; C = carry-out.
REQ-018 SUB: Result = Op1-Op2; C = borrow, i.e. C=1 iff Op1 < Op2 unsigned.
REQ-019 V SHALL flag two's-complement overflow for ADD, ADC and SUB, and SHALL be 0 for all other operations.
REQ-020 AND, OR, NOT and Mem SHALL produce the bitwise result or Op1, with C=0.
REQ-021 FnLSL and FnLSR with n = Op2[SHW-1:0]:
- n=0: Done after 1 cycle, Result=Op1, FSM stays in IDLE.
- n>0: enter SHIFT, shift one bit per cycle with zero fill; Done after n cycles; C = last bit shifted out.
REQ-022 FnMUL (new enum member) SHALL enter MUL and run unsigned shift-add over WIDTH cycles; Done after WIDTH cycles.
REQ-023 MUL: Result = low WIDTH bits of the product; C = 1 iff the high WIDTH bits are nonzero.
REQ-024 For every operation, Z = (Result==0) and N = Result[WIDTH-1], evaluated on the value being written.
REQ-025 Flags and Result SHALL change only in a Done cycle.
REQ-026 Done and the return to IDLE SHALL coincide, so Start in the Done cycle is accepted.
REQ-027 Start and Reset asserted in the same cycle: Reset SHALL win.

Reset
REQ-028 Reset SHALL force: state IDLE, Busy=0, Done=0, Result=0, Flags=0, internal counters and operand registers cleared.
REQ-029 Reset during SHIFT or MUL SHALL abort the operation with no Done pulse.
REQ-030 Reset SHALL take effect on the first rising edge at which it is sampled high.

Structure
REQ-031 FnMUL SHALL be added to alu_functions_t in package opcodes.
REQ-032 Flag bit indices (FLAGS_Z=0, FLAGS_C=1, FLAGS_V=2, FLAGS_N=3) SHALL be package localparams in opcodes, replacing per-file defines.
REQ-033 The FSM state enum SHALL be local to alu_seq.
REQ-034 The single-cycle datapath SHALL be one combinational sub-module, alu_seq_comb, returning the result plus raw C and V.
REQ-035 alu_seq itself SHALL hold the FSM, the counter, the shift/multiply registers and the flag register.

Verification (WIDTH=16)
REQ-036 ADD 0x7FFF+0x0001 at cycle t -> Done at t+1, Result=0x8000, N=1, V=1, C=0, Z=0.
REQ-037 SUB 0x0003-0x0005 -> Result=0xFFFE, C=1, N=1; then ADC 0x0001+0x0001 -> Result=0x0003.
REQ-038 LSL Op1=0x0001, Op2=5 at t, plus a second Start at t+2 -> single Done at t+5, Result=0x0020, C=0; second Start ignored.
REQ-039 MUL 0x0100*0x0100 -> Done at t+16, Result=0x0000, Z=1, C=1; and MUL 0x0003*0x0005 -> Result=0x000F, C=0.
REQ-040 Reset at t+3 of a MUL -> following cycle Busy=0, Result=0, Flags=0, and no Done pulse.
REQ-041 LSR Op1=0xA5A5, Op2=0 -> Done at t+1, Result=0xA5A5, Busy never asserted.
